// File: rtl/video_mode_sequencer.sv
// -----------------------------------------------------------------------------
// video_mode_sequencer
//
// Selects the pattern mode of the caleidoscope generator from the board button.
// The raw button is synchronized and debounced. Each accepted press advances
// the mode by one step, but only at the next frame boundary (vsync rising
// edge). Around every change the HDMI path is muted for a fixed number of
// frames, which hides the partial frame that the change produces. While the
// PLL is unlocked the output stays muted and all button activity is ignored.
// All logic runs on the 25 MHz pixel clock.
//
// Parameters
//   C_debounce_bits : debounce counter width. The input must differ from the
//                     debounced level continuously for 2**N cycles to flip it.
//   C_mute_frames   : frames mute stays high after a mode change (1..255)
//   C_modes         : number of modes. switch wraps C_modes-1 -> 0 (2..8)
//   C_reset_mode    : switch value after reset (< C_modes)
//
// Ports
//   clk_pixel   in   pixel clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   btn         in   raw button, asynchronous, active-high
//   locked      in   PLL locked, asynchronous
//   vsync       in   generator vsync, clk_pixel-synchronous, active-high
//   switch      out  [2:0] mode select to the generator
//   mute        out  1 = force blank on the HDMI path
//   frame_count out  [7:0] count of vsync rising edges, wraps 255 -> 0
//   status      out  [7:0] {locked_s, 2'b00, pending, mute, switch}
// -----------------------------------------------------------------------------
module video_mode_sequencer #(
  parameter int C_debounce_bits = 16,
  parameter int C_mute_frames   = 2,
  parameter int C_modes         = 8,
  parameter int C_reset_mode    = 4
) (
  input  logic       clk_pixel,
  input  logic       rst_n,
  input  logic       btn,
  input  logic       locked,
  input  logic       vsync,
  output logic [2:0] switch,
  output logic       mute,
  output logic [7:0] frame_count,
  output logic [7:0] status
);

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PEND = 2'd1,
    MUTE = 2'd2
  } state_t;

  localparam logic [2:0] RESET_MODE = 3'(C_reset_mode);
  localparam logic [2:0] LAST_MODE  = 3'(C_modes - 1);
  localparam logic [7:0] LAST_MUTE  = 8'(C_mute_frames - 1);

  // Synchronizers and edge detection
  logic btn_m, btn_s;
  logic locked_m, locked_s;
  logic vsync_d;
  logic vs_rise;

  // Debounce
  logic [C_debounce_bits-1:0] cnt;
  logic                       stable;
  logic                       press;

  // Sequencer state
  state_t     state, state_n;
  logic [2:0] switch_n;
  logic       mute_n;
  logic [7:0] mcnt, mcnt_n;
  logic       pending, pending_n;

  assign vs_rise = vsync & ~vsync_d;

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      btn_m    <= 1'b0;
      btn_s    <= 1'b0;
      locked_m <= 1'b0;
      locked_s <= 1'b0;
      vsync_d  <= 1'b0;
    end else begin
      btn_m    <= btn;
      btn_s    <= btn_m;
      locked_m <= locked;
      locked_s <= locked_m;
      vsync_d  <= vsync;
    end
  end

  // The counter measures how long btn_s has disagreed with the debounced
  // level; any return to agreement restarts the measurement. Only the
  // 0->1 transition of the debounced level produces a press pulse.
  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      stable <= 1'b0;
      press  <= 1'b0;
    end else begin
      press <= 1'b0;
      if (btn_s == stable) begin
        cnt <= '0;
      end else if (&cnt) begin
        cnt    <= '0;
        stable <= btn_s;
        press  <= btn_s;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      frame_count <= 8'd0;
    end else if (vs_rise) begin
      frame_count <= frame_count + 8'd1;
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state   <= RUN;
      switch  <= RESET_MODE;
      mute    <= 1'b1;
      mcnt    <= 8'd0;
      pending <= 1'b0;
    end else begin
      state   <= state_n;
      switch  <= switch_n;
      mute    <= mute_n;
      mcnt    <= mcnt_n;
      pending <= pending_n;
    end
  end

  always_comb begin
    state_n   = state;
    switch_n  = switch;
    mute_n    = mute;
    mcnt_n    = mcnt;
    pending_n = pending;
    if (!locked_s) begin
      // Unlocked clock: keep the screen blank and forget queued presses.
      state_n   = RUN;
      mute_n    = 1'b1;
      pending_n = 1'b0;
    end else begin
      case (state)
        RUN: begin
          mute_n = 1'b0;
          if (press || pending) begin
            state_n   = PEND;
            pending_n = 1'b0;
          end
        end
        PEND: begin
          mute_n = 1'b0;
          if (vs_rise) begin
            switch_n = (switch == LAST_MODE) ? 3'd0 : switch + 3'd1;
            mute_n   = 1'b1;
            mcnt_n   = 8'd0;
            state_n  = MUTE;
          end
          // A press that coincides with the frame boundary is queued.
          if (press) begin
            pending_n = 1'b1;
          end
        end
        MUTE: begin
          if (vs_rise) begin
            if (mcnt == LAST_MUTE) begin
              mute_n  = 1'b0;
              state_n = RUN;
            end else begin
              mcnt_n = mcnt + 8'd1;
            end
          end
          if (press) begin
            pending_n = 1'b1;
          end
        end
        default: begin
          state_n = RUN;
          mute_n  = 1'b1;
        end
      endcase
    end
  end

  assign status = {locked_s, 2'b00, pending, mute, switch};

endmodule
